// File: rtl/pim_matmul_sequencer.sv
// Expands one tiled C = A x B job into per-tile memory commands.
// Optional perf counters are enabled with `define PIM_SEQ_PERF_EN.
module pim_matmul_sequencer #(
    parameter int LEN         = 32,
    parameter int DIM_W       = 8,
    parameter int TILE_STRIDE = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN-1:0]   job_a_base,
    input  logic [LEN-1:0]   job_b_base,
    input  logic [LEN-1:0]   job_c_base,
    input  logic [DIM_W-1:0] job_m,
    input  logic [DIM_W-1:0] job_n,
    input  logic [DIM_W-1:0] job_k,
    output logic             job_done,
    output logic [LEN-1:0]   src1_addr,
    output logic [LEN-1:0]   src2_addr,
    output logic [LEN-1:0]   dst_addr,
    output logic             start,
    output logic             mem_accumulate,
    input  logic             mem_done
`ifdef PIM_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_cmds,
    output logic [31:0]      perf_busy_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    localparam logic [LEN-1:0] STRIDE = LEN'(TILE_STRIDE);

    state_t state, state_nxt;

    logic [DIM_W-1:0] i_idx, j_idx, k_idx;
    logic [DIM_W-1:0] m_last, n_last, k_last;
    logic [LEN-1:0]   a_row, b_base, b_col, n_step, k_step;
    logic             accept, advance, last_k, last_j, last_cmd;

    assign last_k   = (k_idx == k_last);
    assign last_j   = (j_idx == n_last);
    assign last_cmd = last_k && last_j && (i_idx == m_last);

    assign mem_accumulate = (state == ISSUE || state == WAIT) && (k_idx != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        job_done  = 1'b0;
        start     = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        unique case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    accept    = 1'b1;
                    state_nxt = (job_m == '0 || job_n == '0 || job_k == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_done) begin
                    advance   = 1'b1;
                    state_nxt = last_cmd ? FIN : ISSUE;
                end
            end
            FIN: begin
                job_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pointers walk incrementally; row/column anchors restore them on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            m_last    <= '0;
            n_last    <= '0;
            k_last    <= '0;
            a_row     <= '0;
            b_base    <= '0;
            b_col     <= '0;
            n_step    <= '0;
            k_step    <= '0;
            src1_addr <= '0;
            src2_addr <= '0;
            dst_addr  <= '0;
        end else if (accept) begin
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            m_last    <= job_m - 1'b1;
            n_last    <= job_n - 1'b1;
            k_last    <= job_k - 1'b1;
            a_row     <= job_a_base;
            b_base    <= job_b_base;
            b_col     <= job_b_base;
            n_step    <= LEN'(job_n) * STRIDE;
            k_step    <= LEN'(job_k) * STRIDE;
            src1_addr <= job_a_base;
            src2_addr <= job_b_base;
            dst_addr  <= job_c_base;
        end else if (advance && !last_cmd) begin
            if (!last_k) begin
                k_idx     <= k_idx + 1'b1;
                src1_addr <= src1_addr + STRIDE;
                src2_addr <= src2_addr + n_step;
            end else begin
                k_idx    <= '0;
                dst_addr <= dst_addr + STRIDE;
                if (!last_j) begin
                    j_idx     <= j_idx + 1'b1;
                    src1_addr <= a_row;
                    src2_addr <= b_col + STRIDE;
                    b_col     <= b_col + STRIDE;
                end else begin
                    j_idx     <= '0;
                    i_idx     <= i_idx + 1'b1;
                    a_row     <= a_row + k_step;
                    src1_addr <= a_row + k_step;
                    src2_addr <= b_base;
                    b_col     <= b_base;
                end
            end
        end
    end

`ifdef PIM_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cmds        <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (start && perf_cmds != '1)
                perf_cmds <= perf_cmds + 1'b1;
            if (state != IDLE && perf_busy_cycles != '1)
                perf_busy_cycles <= perf_busy_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pim_matmul_sequencer.sv
// Directed bench for pim_matmul_sequencer with a command scoreboard.
// Builds with or without PIM_SEQ_PERF_EN.
module tb_pim_matmul_sequencer;

    typedef struct packed {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] d;
        logic        acc;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_a_base, job_b_base, job_c_base;
    logic [7:0]  job_m, job_n, job_k;
    logic        job_done;
    logic [31:0] src1_addr, src2_addr, dst_addr;
    logic        start;
    logic        mem_accumulate;
    logic        mem_done;
    logic        md_model = 1'b0;
    logic        md_spur;
`ifdef PIM_SEQ_PERF_EN
    logic [31:0] perf_cmds, perf_busy_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int done_cnt = 0;
    int cyc = 0;
    int md_cyc = -10;
    int done_cyc = -20;
    int lat = 3;
    int cd = 0;
    cmd_t exp_q[$];

    assign mem_done = md_model | md_spur;

    always #5 clk = ~clk;

    pim_matmul_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_a_base     (job_a_base),
        .job_b_base     (job_b_base),
        .job_c_base     (job_c_base),
        .job_m          (job_m),
        .job_n          (job_n),
        .job_k          (job_k),
        .job_done       (job_done),
        .src1_addr      (src1_addr),
        .src2_addr      (src2_addr),
        .dst_addr       (dst_addr),
        .start          (start),
        .mem_accumulate (mem_accumulate),
        .mem_done       (mem_done)
`ifdef PIM_SEQ_PERF_EN
        ,
        .perf_cmds        (perf_cmds),
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    // Memory responder: mem_done pulses lat cycles after each start.
    always @(negedge clk) begin
        md_model = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) md_model = 1'b1;
        end
        if (start) cd = lat;
    end

    always @(posedge clk) begin
        if (mem_done) md_cyc = cyc;
        if (job_done) begin
            done_cyc = cyc;
            done_cnt = done_cnt + 1;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (start) begin
            cmd_t e, o;
            n_starts = n_starts + 1;
            checks   = checks + 1;
            o = {src1_addr, src2_addr, dst_addr, mem_accumulate};
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $error("FAIL cmd_unexpected observed=%h expected=none", o);
            end else begin
                e = exp_q.pop_front();
                assert (o === e) else begin
                    errors = errors + 1;
                    $error("FAIL cmd observed=%h expected=%h", o, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input logic [31:0] a, b, c, input int m, n, k);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                for (int kk = 0; kk < k; kk++) begin
                    cmd_t e;
                    e.s1  = a + 32'((i * k + kk) * 64);
                    e.s2  = b + 32'((kk * n + j) * 64);
                    e.d   = c + 32'((i * n + j) * 64);
                    e.acc = (kk != 0);
                    exp_q.push_back(e);
                end
    endtask

    task automatic submit(input logic [31:0] a, b, c, input int m, n, k);
        bit took = 1'b0;
        @(negedge clk);
        job_a_base = a;
        job_b_base = b;
        job_c_base = c;
        job_m      = 8'(m);
        job_n      = 8'(n);
        job_k      = 8'(k);
        job_valid  = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (job_ready) begin
                @(posedge clk);
                took = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 job_valid = 1'b0;
        if (!took) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (job_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, d0;
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_a_base = '0;
        job_b_base = '0;
        job_c_base = '0;
        job_m      = '0;
        job_n      = '0;
        job_k      = '0;
        md_spur    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(job_ready), 32'd1);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_done", 32'(job_done), 32'd0);
        chk("rst_src1", src1_addr, 32'd0);
        chk("rst_src2", src2_addr, 32'd0);
        chk("rst_dst", dst_addr, 32'd0);
        chk("rst_acc", 32'(mem_accumulate), 32'd0);
        rst = 1'b0;

        // single tile, mem latency 3
        lat = 3;
        s0  = n_starts;
        push_job(32'h100, 32'h200, 32'h300, 1, 1, 1);
        submit(32'h100, 32'h200, 32'h300, 1, 1, 1);
        @(negedge clk);
        chk("t1_first_start", 32'(start), 32'd1);
        chk("t1_ready_busy", 32'(job_ready), 32'd0);
        wait_done(50);
        chk("t1_done_lat", 32'(done_cyc), 32'(md_cyc + 1));
        chk("t1_starts", 32'(n_starts - s0), 32'd1);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 1x2x2 with fast memory
        lat = 1;
        s0  = n_starts;
        push_job(32'h100, 32'h200, 32'h300, 1, 2, 2);
        submit(32'h100, 32'h200, 32'h300, 1, 2, 2);
        wait_done(100);
        chk("t2_starts", 32'(n_starts - s0), 32'd4);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_done_lat", 32'(done_cyc), 32'(md_cyc + 1));

        // K = 0: no commands, immediate done
        s0 = n_starts;
        submit(32'h100, 32'h200, 32'h300, 2, 2, 0);
        @(negedge clk);
        chk("t3_done", 32'(job_done), 32'd1);
        chk("t3_ready_fin", 32'(job_ready), 32'd0);
        @(negedge clk);
        chk("t3_ready_back", 32'(job_ready), 32'd1);
        chk("t3_done_off", 32'(job_done), 32'd0);
        chk("t3_no_starts", 32'(n_starts - s0), 32'd0);

        // spurious mem_done while idle
        @(negedge clk);
        md_spur = 1'b1;
        @(negedge clk);
        md_spur = 1'b0;
        chk("t4_idle_ready", 32'(job_ready), 32'd1);
        chk("t4_idle_start", 32'(start), 32'd0);
        chk("t4_idle_done", 32'(job_done), 32'd0);

        // address wrap, plus mem_done during ISSUE
        lat = 2;
        s0  = n_starts;
        push_job(32'hFFFF_FFC0, 32'h200, 32'h300, 1, 1, 2);
        submit(32'hFFFF_FFC0, 32'h200, 32'h300, 1, 1, 2);
        md_spur = 1'b1;
        @(posedge clk);
        #1 md_spur = 1'b0;
        wait_done(100);
        chk("t5_starts", 32'(n_starts - s0), 32'd2);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // reset in WAIT abandons the job
        lat = 3;
        push_job(32'h1000, 32'h2000, 32'h3000, 2, 2, 2);
        submit(32'h1000, 32'h2000, 32'h3000, 2, 2, 2);
        @(negedge clk);
        @(negedge clk);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("t6_rst_ready", 32'(job_ready), 32'd1);
        chk("t6_rst_start", 32'(start), 32'd0);
        chk("t6_rst_src1", src1_addr, 32'd0);
        chk("t6_rst_dst", dst_addr, 32'd0);
        chk("t6_rst_acc", 32'(mem_accumulate), 32'd0);
        repeat (6) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);

        s0 = n_starts;
        push_job(32'h100, 32'h200, 32'h300, 1, 1, 1);
        submit(32'h100, 32'h200, 32'h300, 1, 1, 1);
        wait_done(50);
        chk("t7_starts", 32'(n_starts - s0), 32'd1);
        chk("t7_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef PIM_SEQ_PERF_EN
        chk("t7_perf_cmds", perf_cmds, 32'd1);
        chk("t7_perf_busy", perf_busy_cycles, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
